// File: rtl/coherence_ctrl.sv
// -----------------------------------------------------------------------------
// coherence_ctrl
//
// Bus/coherence controller between two cores' L1 caches (icache + dcache each)
// and one shared RAM port. It arbitrates instruction fetches, dcache
// write-backs and coherent dcache block reads. It snoops the other core's
// dcache and sequences cache-to-cache transfers. During such a transfer the
// supplied block is written back to RAM at the same time.
//
// Handshake: a cache raises a request (iREN / dREN / dWEN / cctrans) and holds
// it, together with its address and data, until the matching iwait/dwait bit
// drops low. A low wait bit lasts exactly one cycle and means "this word is
// done". Each dcache block is two words. The cache presents the second word's
// address after the first wait pulse.
//
// Ports (index [i] = core i, j = ~i is the other core):
//   CLK, nRST            clock, async active-low reset
//   iREN, iaddr          fetch request / address          (in)
//   iwait, iload         fetch stall / data               (out)
//   dREN, dWEN           dcache read / write-back request (in)
//   daddr, dstore        dcache word address / store data (in)
//   cctrans, ccwrite     coherent request / exclusive-or-modified flag (in)
//   dwait, dload         data stall / read data           (out)
//   ccwait, ccinv        snoop active / invalidate        (out)
//   ccsnoopaddr          snoop address                    (out)
//   ramREN, ramWEN       RAM read / write strobes         (out)
//   ramaddr, ramstore    RAM address / write data         (out)
//   ramload, ramstate    RAM read data / status (10 = ACCESS) (in)
//   fsm_state            current controller state, for observation (out)
// -----------------------------------------------------------------------------
module coherence_ctrl #(
  parameter int CPUS = 2
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [CPUS-1:0]           iREN,
  input  logic [CPUS-1:0][31:0]     iaddr,
  output logic [CPUS-1:0]           iwait,
  output logic [CPUS-1:0][31:0]     iload,
  input  logic [CPUS-1:0]           dREN,
  input  logic [CPUS-1:0]           dWEN,
  input  logic [CPUS-1:0][31:0]     daddr,
  input  logic [CPUS-1:0][31:0]     dstore,
  input  logic [CPUS-1:0]           cctrans,
  input  logic [CPUS-1:0]           ccwrite,
  output logic [CPUS-1:0]           dwait,
  output logic [CPUS-1:0][31:0]     dload,
  output logic [CPUS-1:0]           ccwait,
  output logic [CPUS-1:0]           ccinv,
  output logic [CPUS-1:0][31:0]     ccsnoopaddr,
  output logic                      ramREN,
  output logic                      ramWEN,
  output logic [31:0]               ramaddr,
  output logic [31:0]               ramstore,
  input  logic [31:0]               ramload,
  input  logic [1:0]                ramstate,
  output logic [3:0]                fsm_state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_IFETCH = 4'd1;
  localparam logic [3:0] S_WB0    = 4'd2;
  localparam logic [3:0] S_WB1    = 4'd3;
  localparam logic [3:0] S_SNOOP  = 4'd4;
  localparam logic [3:0] S_SNPCHK = 4'd5;
  localparam logic [3:0] S_C2C0   = 4'd6;
  localparam logic [3:0] S_C2C1   = 4'd7;
  localparam logic [3:0] S_RAMRD0 = 4'd8;
  localparam logic [3:0] S_RAMRD1 = 4'd9;
  localparam logic [3:0] S_INV    = 4'd10;

  localparam logic [1:0] RAM_ACCESS = 2'b10;

  logic [3:0]      state, state_next;
  logic            g;          // granted core, held for the whole transaction
  logic            j;          // the other core
  logic            dprio;      // core that wins the next data tie
  logic            iprio;      // core that wins the next fetch tie
  logic [CPUS-1:0] dreq;
  logic            dwin, iwin, win;
  logic            grant_d, grant_i;
  logic            access;

  assign j         = ~g;
  assign access    = (ramstate == RAM_ACCESS);
  assign dreq      = dREN | dWEN | cctrans;
  assign fsm_state = state;

  // A lone requester wins outright. On a tie the priority pointer decides.
  assign dwin = (dreq[0] & dreq[1]) ? dprio : dreq[1];
  assign iwin = (iREN[0] & iREN[1]) ? iprio : iREN[1];

  // Next-state and grant logic
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    win        = g;
    case (state)
      S_IDLE: begin
        if (|dreq) begin
          grant_d = 1'b1;
          win     = dwin;
          if (dWEN[dwin] & ~cctrans[dwin])
            state_next = S_WB0;
          else if (cctrans[dwin])
            state_next = S_SNOOP;
          else
            // A plain non-coherent read has no snoop. It goes straight to RAM,
            // so it cannot stall arbitration forever.
            state_next = S_RAMRD0;
        end else if (|iREN) begin
          grant_i    = 1'b1;
          win        = iwin;
          state_next = S_IFETCH;
        end
      end
      S_IFETCH: if (access) state_next = S_IDLE;
      S_WB0:    if (access) state_next = S_WB1;
      S_WB1:    if (access) state_next = S_IDLE;
      S_SNOOP:  state_next = S_SNPCHK;
      S_SNPCHK: begin
        // Upgrade: the requester has no read, so only invalidation is needed.
        if (~dREN[g])
          state_next = S_INV;
        else if (ccwrite[j])
          state_next = S_C2C0;
        else
          state_next = S_RAMRD0;
      end
      S_C2C0:   if (access) state_next = S_C2C1;
      S_C2C1:   if (access) state_next = S_IDLE;
      S_RAMRD0: if (access) state_next = S_RAMRD1;
      S_RAMRD1: if (access) state_next = S_IDLE;
      S_INV:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
      g     <= 1'b0;
      dprio <= 1'b0;
      iprio <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_d | grant_i) g <= win;
      if (grant_d) dprio <= ~win;
      if (grant_i) iprio <= ~win;
    end
  end

  // Output decode
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    for (int k = 0; k < CPUS; k++) begin
      iload[k] = ramload;
      dload[k] = ramload;
    end
    case (state)
      S_IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[g];
        if (access) iwait[g] = 1'b0;
      end
      S_WB0, S_WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[g];
        ramstore = dstore[g];
        if (access) dwait[g] = 1'b0;
      end
      S_SNOOP, S_SNPCHK: begin
        ccwait[j]      = 1'b1;
        ccsnoopaddr[j] = daddr[g];
        ccinv[j]       = ccwrite[g];
      end
      S_C2C0, S_C2C1: begin
        // The snooped cache supplies the block. The same word goes to RAM and
        // to the requester, and both caches step forward on the ACCESS cycle.
        ccwait[j] = 1'b1;
        ramWEN    = 1'b1;
        ramaddr   = daddr[j];
        ramstore  = dstore[j];
        dload[g]  = dstore[j];
        if (access) begin
          dwait[g] = 1'b0;
          dwait[j] = 1'b0;
        end
      end
      S_RAMRD0, S_RAMRD1: begin
        ramREN  = 1'b1;
        ramaddr = daddr[g];
        if (access) dwait[g] = 1'b0;
      end
      S_INV: dwait[g] = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coherence_ctrl
//
// Directed bench for coherence_ctrl. Inputs change 1 time unit after a rising
// edge. Outputs are checked 1 time unit after that, well away from the edge.
// -----------------------------------------------------------------------------
module tb_coherence_ctrl;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_IFETCH = 4'd1;
  localparam logic [3:0] S_WB0    = 4'd2;
  localparam logic [3:0] S_WB1    = 4'd3;
  localparam logic [3:0] S_SNOOP  = 4'd4;
  localparam logic [3:0] S_SNPCHK = 4'd5;
  localparam logic [3:0] S_C2C0   = 4'd6;
  localparam logic [3:0] S_C2C1   = 4'd7;
  localparam logic [3:0] S_INV    = 4'd10;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  logic             CLK;
  logic             nRST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN, dWEN;
  logic [1:0][31:0] daddr, dstore;
  logic [1:0]       cctrans, ccwrite;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       ccwait, ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;
  logic [3:0]       fsm_state;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  coherence_ctrl #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .fsm_state(fsm_state)
  );

  // Clock / watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Fetch tie between both cores. first = core expected to be served first.
  task automatic fetch_tie(input logic first);
    iREN     = 2'b11;
    iaddr[0] = 32'h300;
    iaddr[1] = 32'h400;
    ramstate = ACCESS;
    ramload  = 32'h5555_0000;
    settle();
    chk("tie_idle_iwait", {30'd0, iwait}, 32'h3);
    tick();
    chk("tie_first_addr", ramaddr, first ? 32'h400 : 32'h300);
    chk("tie_first_iwait", {30'd0, iwait}, first ? 32'h1 : 32'h2);
    tick();
    iREN[first] = 1'b0;
    settle();
    chk("tie_gap_state", {28'd0, fsm_state}, {28'd0, S_IDLE});
    tick();
    chk("tie_second_addr", ramaddr, first ? 32'h300 : 32'h400);
    chk("tie_second_iwait", {30'd0, iwait}, first ? 32'h2 : 32'h1);
    tick();
    iREN     = 2'b00;
    ramstate = FREE;
    settle();
  endtask

  // Directed sequence
  initial begin
    nRST = 1'b0; iREN = '0; iaddr = '0; dREN = '0; dWEN = '0;
    daddr = '0; dstore = '0; cctrans = '0; ccwrite = '0;
    ramload = '0; ramstate = FREE;
    #2;
    chk("rst_state",  {28'd0, fsm_state}, {28'd0, S_IDLE});
    chk("rst_dwait",  {30'd0, dwait}, 32'h3);
    chk("rst_iwait",  {30'd0, iwait}, 32'h3);
    chk("rst_ramren", {31'd0, ramREN}, 32'h0);
    chk("rst_ramwen", {31'd0, ramWEN}, 32'h0);
    chk("rst_ccwait", {30'd0, ccwait}, 32'h0);
    tick(); tick();
    nRST = 1'b1;

    // Fetch by core 0, two BUSY cycles then ACCESS
    iREN[0] = 1'b1; iaddr[0] = 32'h100; ramstate = BUSY; ramload = 32'hCAFE_0001;
    settle();
    chk("if_grant_cycle_ren", {31'd0, ramREN}, 32'h0);
    tick();
    chk("if_state", {28'd0, fsm_state}, {28'd0, S_IFETCH});
    chk("if_busy1_ren", {31'd0, ramREN}, 32'h1);
    chk("if_busy1_addr", ramaddr, 32'h100);
    chk("if_busy1_iwait", {30'd0, iwait}, 32'h3);
    tick();
    chk("if_busy2_ren", {31'd0, ramREN}, 32'h1);
    chk("if_busy2_iwait", {30'd0, iwait}, 32'h3);
    tick();
    ramstate = ACCESS;
    settle();
    chk("if_acc_ren", {31'd0, ramREN}, 32'h1);
    chk("if_acc_addr", ramaddr, 32'h100);
    chk("if_acc_iwait", {30'd0, iwait}, 32'h2);
    chk("if_acc_iload", iload[0], 32'hCAFE_0001);
    tick();
    iREN = 2'b00; ramstate = FREE;
    settle();
    chk("if_done_state", {28'd0, fsm_state}, {28'd0, S_IDLE});
    chk("if_done_ren", {31'd0, ramREN}, 32'h0);

    // Core 0 was just served, so core 1 wins this tie
    fetch_tie(1'b1);

    // Fresh reset restores core 0 priority
    nRST = 1'b0;
    settle();
    chk("rst2_state", {28'd0, fsm_state}, {28'd0, S_IDLE});
    nRST = 1'b1;
    settle();
    fetch_tie(1'b0);

    // Core 0 coherent read, snooped cache clean -> RAM reads
    dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite = 2'b00;
    daddr[0] = 32'h200; ramstate = BUSY;
    settle();
    chk("rd_idle_ccwait", {30'd0, ccwait}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rd_snp_state", {28'd0, fsm_state}, c == 0 ? {28'd0, S_SNOOP} : {28'd0, S_SNPCHK});
      chk("rd_snp_ccwait", {30'd0, ccwait}, 32'h2);
      chk("rd_snp_addr", ccsnoopaddr[1], 32'h200);
      chk("rd_snp_ccinv", {30'd0, ccinv}, 32'h0);
      chk("rd_snp_ramren", {31'd0, ramREN}, 32'h0);
    end
    tick();
    chk("rd_w0_busy_ren", {31'd0, ramREN}, 32'h1);
    chk("rd_w0_busy_addr", ramaddr, 32'h200);
    chk("rd_w0_busy_dwait", {30'd0, dwait}, 32'h3);
    tick();
    ramstate = ACCESS; ramload = 32'hAAAA_0000;
    settle();
    chk("rd_w0_dwait", {30'd0, dwait}, 32'h2);
    chk("rd_w0_dload", dload[0], 32'hAAAA_0000);
    tick();
    daddr[0] = 32'h204; ramload = 32'hAAAA_0004;
    settle();
    chk("rd_w1_addr", ramaddr, 32'h204);
    chk("rd_w1_dwait", {30'd0, dwait}, 32'h2);
    chk("rd_w1_dload", dload[0], 32'hAAAA_0004);
    tick();
    dREN = 2'b00; cctrans = 2'b00; ramstate = FREE;
    settle();
    chk("rd_done_state", {28'd0, fsm_state}, {28'd0, S_IDLE});
    chk("rd_done_ren", {31'd0, ramREN}, 32'h0);

    // Core 1 read-exclusive, core 0 holds it Modified -> cache-to-cache
    dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h500;
    daddr[0] = 32'h500; dstore[0] = 32'hDEAD_BEEF; ccwrite[0] = 1'b0;
    settle();
    tick();
    chk("c2c_snp_ccwait", {30'd0, ccwait}, 32'h1);
    chk("c2c_snp_ccinv", {30'd0, ccinv}, 32'h1);
    chk("c2c_snp_addr", ccsnoopaddr[0], 32'h500);
    ccwrite[0] = 1'b1;
    settle();
    tick();
    chk("c2c_chk_state", {28'd0, fsm_state}, {28'd0, S_SNPCHK});
    chk("c2c_chk_ccinv", {30'd0, ccinv}, 32'h1);
    ramstate = BUSY;
    settle();
    tick();
    chk("c2c_state", {28'd0, fsm_state}, {28'd0, S_C2C0});
    chk("c2c_w0_wen", {31'd0, ramWEN}, 32'h1);
    chk("c2c_w0_addr", ramaddr, 32'h500);
    chk("c2c_w0_store", ramstore, 32'hDEAD_BEEF);
    chk("c2c_w0_dload", dload[1], 32'hDEAD_BEEF);
    chk("c2c_w0_ccwait", {30'd0, ccwait}, 32'h1);
    chk("c2c_w0_busy_dwait", {30'd0, dwait}, 32'h3);
    tick();
    ramstate = ACCESS;
    settle();
    chk("c2c_w0_acc_dwait", {30'd0, dwait}, 32'h0);
    tick();
    daddr[0] = 32'h504; daddr[1] = 32'h504; dstore[0] = 32'h0BAD_F00D;
    settle();
    chk("c2c_w1_state", {28'd0, fsm_state}, {28'd0, S_C2C1});
    chk("c2c_w1_addr", ramaddr, 32'h504);
    chk("c2c_w1_store", ramstore, 32'h0BAD_F00D);
    chk("c2c_w1_dload", dload[1], 32'h0BAD_F00D);
    chk("c2c_w1_dwait", {30'd0, dwait}, 32'h0);
    tick();
    dREN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00; ramstate = FREE;
    settle();
    chk("c2c_done_state", {28'd0, fsm_state}, {28'd0, S_IDLE});
    chk("c2c_done_ccwait", {30'd0, ccwait}, 32'h0);
    chk("c2c_done_wen", {31'd0, ramWEN}, 32'h0);

    // Core 0 upgrade -> SNOOP, SNPCHK, INV with no RAM traffic
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h600;
    settle();
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("upg_ccinv", {30'd0, ccinv}, 32'h2);
      chk("upg_ccwait", {30'd0, ccwait}, 32'h2);
      chk("upg_snp_addr", ccsnoopaddr[1], 32'h600);
      chk("upg_snp_ram", {30'd0, ramREN, ramWEN}, 32'h0);
      chk("upg_snp_dwait", {30'd0, dwait}, 32'h3);
    end
    tick();
    chk("upg_inv_state", {28'd0, fsm_state}, {28'd0, S_INV});
    chk("upg_inv_dwait", {30'd0, dwait}, 32'h2);
    chk("upg_inv_ram", {30'd0, ramREN, ramWEN}, 32'h0);
    chk("upg_inv_ccinv", {30'd0, ccinv}, 32'h0);
    tick();
    cctrans = 2'b00; ccwrite = 2'b00;
    settle();
    chk("upg_done_state", {28'd0, fsm_state}, {28'd0, S_IDLE});
    chk("upg_done_dwait", {30'd0, dwait}, 32'h3);

    // Eviction by core 1 beats a simultaneous fetch by core 0
    dWEN[1] = 1'b1; daddr[1] = 32'h700; dstore[1] = 32'h77;
    iREN[0] = 1'b1; iaddr[0] = 32'h800; ramstate = ACCESS; ramload = 32'h8888_0000;
    settle();
    tick();
    chk("ev_state", {28'd0, fsm_state}, {28'd0, S_WB0});
    chk("ev_w0_wen", {31'd0, ramWEN}, 32'h1);
    chk("ev_w0_ren", {31'd0, ramREN}, 32'h0);
    chk("ev_w0_addr", ramaddr, 32'h700);
    chk("ev_w0_store", ramstore, 32'h77);
    chk("ev_w0_dwait", {30'd0, dwait}, 32'h1);
    chk("ev_w0_iwait", {30'd0, iwait}, 32'h3);
    tick();
    daddr[1] = 32'h704; dstore[1] = 32'h78;
    settle();
    chk("ev_w1_state", {28'd0, fsm_state}, {28'd0, S_WB1});
    chk("ev_w1_addr", ramaddr, 32'h704);
    chk("ev_w1_store", ramstore, 32'h78);
    chk("ev_w1_dwait", {30'd0, dwait}, 32'h1);
    tick();
    dWEN = 2'b00;
    settle();
    chk("ev_gap_state", {28'd0, fsm_state}, {28'd0, S_IDLE});
    tick();
    chk("ev_if_state", {28'd0, fsm_state}, {28'd0, S_IFETCH});
    chk("ev_if_addr", ramaddr, 32'h800);
    chk("ev_if_iwait", {30'd0, iwait}, 32'h2);
    chk("ev_if_iload", iload[0], 32'h8888_0000);
    tick();
    iREN = 2'b00;
    settle();

    // Second eviction, reset asserted during WB1
    dWEN[1] = 1'b1; daddr[1] = 32'h710; dstore[1] = 32'h99;
    settle();
    tick();
    chk("rst_ev_w0_wen", {31'd0, ramWEN}, 32'h1);
    tick();
    ramstate = BUSY; daddr[1] = 32'h714;
    settle();
    chk("rst_ev_w1_state", {28'd0, fsm_state}, {28'd0, S_WB1});
    chk("rst_ev_w1_wen", {31'd0, ramWEN}, 32'h1);
    nRST = 1'b0;
    settle();
    chk("async_rst_state", {28'd0, fsm_state}, {28'd0, S_IDLE});
    chk("async_rst_wen", {31'd0, ramWEN}, 32'h0);
    chk("async_rst_addr", ramaddr, 32'h0);
    chk("async_rst_store", ramstore, 32'h0);
    chk("async_rst_dwait", {30'd0, dwait}, 32'h3);
    dWEN = 2'b00; ramstate = FREE;
    settle();
    nRST = 1'b1;
    tick();
    chk("post_rst_state", {28'd0, fsm_state}, {28'd0, S_IDLE});
    chk("post_rst_wen", {31'd0, ramWEN}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
